mem_access_initiator: RTL and testbench

- M-stage initiator for the data-memory bus: accepts one load/store per instruction from the pipeline and issues a single-beat request (word address, byte enables, lane-aligned write data).
- Stalls the pipeline until the memory responds, then returns the sign- or zero-extended load result.
- Sits between the M-stage pipeline register and a multi-cycle data memory that completes with a req/ack handshake.

---
 rtl/mem_access_pkg.sv | 59 +++++
 rtl/mem_lane_align.sv | 28 ++
 rtl/mem_access_initiator.sv | 161 ++++++++++++++++
 tb/tb_mem_access_initiator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory initiator: size codes, FSM states, lane helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_t;

  // Byte enables for a single-beat access; size 11 behaves as a word.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Pick the addressed lane out of a read word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] a,
                                               input logic [31:0] rdata, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'h0, b};
      SZ_HALF: r = sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // True when the access does not sit on its natural boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: byte enables, lane-replicated store data, extended load data.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        sign_ext,
  output logic [3:0]  be,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext
);

  // Store data is replicated into every lane so the byte enables alone pick the target.
  always_comb begin
    be        = be_gen(size, addr_lo);
    rdata_ext = lane_extract(size, addr_lo, rdata, sign_ext);
    case (size)
      SZ_BYTE: wdata_al = {4{wdata[7:0]}};
      SZ_HALF: wdata_al = {2{wdata[15:0]}};
      default: wdata_al = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_initiator.sv
// M-stage load/store initiator: one single-beat req/ack access per instruction.
// Latency: 3 cycles minimum (IDLE, REQ, RESP), REQ stretches until ack or TIMEOUT_CYCLES.
// Backpressure: stalls the pipeline until RESP; optional MEM_ALIGN_CHECK_EN traps misaligned accesses.
module mem_access_initiator
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              op_store,
  input  logic [1:0]        op_size,
  input  logic              op_signed,
  input  logic [ADDR_W-1:0] AO_M,
  input  logic [31:0]       WDM_M,
  input  logic [31:0]       PC_M,
  output logic              stall,
  output logic              done,
  output logic [31:0]       DMout_M,
  output logic              bus_err,
  output logic              addr_exc,
  output logic [31:0]       err_pc,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              st_q, sgn_q, err_q, exc_q;
  logic [1:0]        sz_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q, pc_q, rd_q, err_pc_q;
  logic [15:0]       cnt_q;
  logic              timeout_hit, misalign_in;
  logic [3:0]        be_w;
  logic [31:0]       wdata_al, rdata_ext;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_in = misaligned(op_size, AO_M[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  // Last permitted REQ cycle; an ack in this same cycle still completes cleanly.
  assign timeout_hit = (cnt_q == TO_LAST);
  assign err_pc      = err_pc_q;

  mem_lane_align u_align (
    .size      (sz_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wd_q),
    .rdata     (rd_q),
    .sign_ext  (sgn_q),
    .be        (be_w),
    .wdata_al  (wdata_al),
    .rdata_ext (rdata_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: misaligned accesses skip the bus entirely when trapping is built in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (op_valid) state_d = misalign_in ? RESP : REQ;
      REQ:     if (bus_ack || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, timeout counter, read capture and error bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= 1'b0;
      sgn_q    <= 1'b0;
      sz_q     <= 2'b00;
      addr_q   <= '0;
      wd_q     <= 32'h0;
      pc_q     <= 32'h0;
      rd_q     <= 32'h0;
      cnt_q    <= 16'h0;
      err_q    <= 1'b0;
      exc_q    <= 1'b0;
      err_pc_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            st_q   <= op_store;
            sgn_q  <= op_signed;
            sz_q   <= op_size;
            addr_q <= AO_M;
            wd_q   <= WDM_M;
            pc_q   <= PC_M;
            rd_q   <= 32'h0;
            cnt_q  <= 16'h0;
            err_q  <= 1'b0;
            exc_q  <= misalign_in;
            if (misalign_in) err_pc_q <= PC_M;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 16'd1;
          if (bus_ack) begin
            rd_q <= bus_rdata;
          end else if (timeout_hit) begin
            err_q    <= 1'b1;
            err_pc_q <= pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: bus signals only in REQ, completion signals only in RESP.
  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    DMout_M   = 32'h0;
    bus_err   = 1'b0;
    addr_exc  = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'h0;
    bus_wdata = 32'h0;
    case (state_q)
      IDLE: stall = op_valid;
      REQ: begin
        stall     = 1'b1;
        bus_req   = 1'b1;
        bus_we    = st_q;
        bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus_be    = be_w;
        bus_wdata = wdata_al;
      end
      RESP: begin
        done     = 1'b1;
        bus_err  = err_q;
        addr_exc = exc_q;
        DMout_M  = (st_q || err_q || exc_q) ? 32'h0 : rdata_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator with a timeout of 4 REQ cycles.
// Latency: drives one access at a time and scores its bus request and completion.
// Backpressure: the bench plays the memory, choosing when to ack.
module tb_mem_access_initiator;

  logic        clk, reset;
  logic        op_valid, op_store, op_signed;
  logic [1:0]  op_size;
  logic [31:0] AO_M, WDM_M, PC_M;
  logic        stall, done, bus_err, addr_exc;
  logic [31:0] DMout_M, err_pc;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_errors = 0;

  // Per-access observations.
  logic [31:0] r_addr, r_wdata, r_dmout, r_err_pc;
  logic [3:0]  r_be;
  logic        r_we, r_bus_err, r_addr_exc;
  int          r_req, r_stall, r_done;

  mem_access_initiator #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_store(op_store), .op_size(op_size), .op_signed(op_signed),
    .AO_M(AO_M), .WDM_M(WDM_M), .PC_M(PC_M),
    .stall(stall), .done(done), .DMout_M(DMout_M), .bus_err(bus_err), .addr_exc(addr_exc),
    .err_pc(err_pc), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one access; ack_after is the REQ-cycle index carrying the ack (-1 = never).
  task automatic do_access(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                           input int ack_after, input logic [31:0] rdata);
    logic seen;
    seen    = 1'b0;
    r_req   = 0;
    r_stall = 0;
    r_done  = 0;
    r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'h0; r_we = 1'b0;
    r_dmout = 32'h0; r_bus_err = 1'b0; r_addr_exc = 1'b0; r_err_pc = 32'h0;
    op_valid = 1'b1; op_store = st; op_size = sz; op_signed = sg;
    AO_M = addr; WDM_M = wd; PC_M = pc;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      #1;
      if (stall) r_stall++;
      if (bus_req) begin
        if (r_req == 0) begin
          r_addr = bus_addr; r_wdata = bus_wdata; r_be = bus_be; r_we = bus_we;
        end
        if (r_req == ack_after) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end
        r_req++;
      end
      if (done) begin
        seen       = 1'b1;
        r_done++;
        r_dmout    = DMout_M;
        r_bus_err  = bus_err;
        r_addr_exc = addr_exc;
        r_err_pc   = err_pc;
      end
      @(posedge clk);
      #1;
      op_valid  = 1'b0;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
    end
    if (!seen) check("access_completed", 32'(seen), 32'h1);
    #1;
    if (done) r_done++;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_store = 1'b0; op_size = 2'b00; op_signed = 1'b0;
    AO_M = 32'h0; WDM_M = 32'h0; PC_M = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_stall",   32'(stall),   32'h0);
    check("rst_done",    32'(done),    32'h0);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_bus_be",  32'(bus_be),  32'h0);
    check("rst_bus_addr", bus_addr,    32'h0);
    check("rst_wdata",   bus_wdata,    32'h0);
    check("rst_dmout",   DMout_M,      32'h0);
    check("rst_err_pc",  err_pc,       32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_addr_exc", 32'(addr_exc), 32'h0);

    // Word store, ack on the second REQ cycle.
    do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h100, 1, 32'h0);
    check("wst_addr",  r_addr,          32'h10);
    check("wst_be",    32'(r_be),       32'hF);
    check("wst_wdata", r_wdata,         32'hDEADBEEF);
    check("wst_we",    32'(r_we),       32'h1);
    check("wst_stall", 32'(r_stall),    32'd3);
    check("wst_done",  32'(r_done),     32'd1);
    check("wst_dmout", r_dmout,         32'h0);

    // Signed and unsigned byte loads from lane 3, immediate ack.
    do_access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h104, 0, 32'h80123456);
    check("lbs_addr",  r_addr,        32'h10);
    check("lbs_be",    32'(r_be),     32'h8);
    check("lbs_we",    32'(r_we),     32'h0);
    check("lbs_dmout", r_dmout,       32'hFFFFFF80);
    check("lbs_stall", 32'(r_stall),  32'd2);
    do_access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h108, 0, 32'h80123456);
    check("lbu_dmout", r_dmout,       32'h00000080);

    // Half store to the upper half, byte store to lane 1.
    do_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'h10C, 0, 32'h0);
    check("sh_addr",  r_addr,     32'h20);
    check("sh_be",    32'(r_be),  32'hC);
    check("sh_wdata", r_wdata,    32'hABCDABCD);
    do_access(1'b1, 2'b00, 1'b0, 32'h1, 32'h0000005A, 32'h110, 0, 32'h0);
    check("sb_be",    32'(r_be),  32'h2);
    check("sb_wdata", r_wdata,    32'h5A5A5A5A);

    // Signed half load from the upper half.
    do_access(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h114, 0, 32'h80017FFF);
    check("lhs_addr",  r_addr,    32'h4);
    check("lhs_be",    32'(r_be), 32'hC);
    check("lhs_dmout", r_dmout,   32'hFFFF8001);

    // No ack: abort after 4 REQ cycles.
    do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h400, -1, 32'h0);
    check("to_req_cycles", 32'(r_req),     32'd4);
    check("to_bus_err",    32'(r_bus_err), 32'h1);
    check("to_dmout",      r_dmout,        32'h0);
    check("to_err_pc",     r_err_pc,       32'h400);
    check("to_done",       32'(r_done),    32'd1);
    check("to_stall",      32'(r_stall),   32'd5);

    // Ack in the timeout cycle wins.
    do_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h404, 3, 32'hCAFEF00D);
    check("tw_req_cycles", 32'(r_req),     32'd4);
    check("tw_bus_err",    32'(r_bus_err), 32'h0);
    check("tw_dmout",      r_dmout,        32'hCAFEF00D);
    check("tw_err_pc",     r_err_pc,       32'h400);

    // Reset while in REQ abandons the access.
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'b10; op_signed = 1'b0;
    AO_M = 32'h80; WDM_M = 32'h0; PC_M = 32'h600;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    #1;
    check("rr_req_before", 32'(bus_req), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rr_req_after",   32'(bus_req), 32'h0);
    check("rr_stall_after", 32'(stall),   32'h0);
    check("rr_err_pc",      err_pc,       32'h0);
    do_access(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h604, 0, 32'h00000011);
    check("rr_next_dmout", r_dmout,     32'h11);
    check("rr_next_done",  32'(r_done), 32'd1);

    // Misaligned word load.
    do_access(1'b0, 2'b10, 1'b0, 32'h31, 32'h0, 32'h500, 0, 32'h13579BDF);
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_req_cycles", 32'(r_req),      32'd0);
    check("mis_addr_exc",   32'(r_addr_exc), 32'h1);
    check("mis_dmout",      r_dmout,         32'h0);
    check("mis_err_pc",     r_err_pc,        32'h500);
    check("mis_done",       32'(r_done),     32'd1);
`else
    check("mis_addr",       r_addr,          32'h30);
    check("mis_req_cycles", 32'(r_req),      32'd1);
    check("mis_addr_exc",   32'(r_addr_exc), 32'h0);
    check("mis_dmout",      r_dmout,         32'h13579BDF);
    check("mis_done",       32'(r_done),     32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
